// File: rtl/character_move_scheduler_if.sv
// character_move_scheduler_if: register-file and movement-logic buses of the move scheduler
interface character_move_scheduler_if #(
    parameter int COORD_W = 5
);
    logic               reg_en;
    logic               reg_rw;
    logic [2:0]         reg_type;
    logic [COORD_W-1:0] reg_x_in;
    logic [COORD_W-1:0] reg_y_in;
    logic [COORD_W-1:0] reg_x_out;
    logic [COORD_W-1:0] reg_y_out;
    logic               mv_req;
    logic [2:0]         mv_type;
    logic [COORD_W-1:0] mv_x;
    logic [COORD_W-1:0] mv_y;
    logic               mv_ack;
    logic               mv_ok;
    logic [COORD_W-1:0] mv_x_new;
    logic [COORD_W-1:0] mv_y_new;

    modport master (
        output reg_en, reg_rw, reg_type, reg_x_in, reg_y_in,
        output mv_req, mv_type, mv_x, mv_y,
        input  reg_x_out, reg_y_out, mv_ack, mv_ok, mv_x_new, mv_y_new
    );

    modport slave (
        input  reg_en, reg_rw, reg_type, reg_x_in, reg_y_in,
        input  mv_req, mv_type, mv_x, mv_y,
        output reg_x_out, reg_y_out, mv_ack, mv_ok, mv_x_new, mv_y_new
    );
endinterface

// File: rtl/character_move_scheduler.sv
// character_move_scheduler: per-tick read / move / write-back sweep over all characters
module character_move_scheduler #(
    parameter int NUM_CHARS   = 5,
    parameter int COORD_W     = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic tick,
    input  logic clear_err,
    output logic busy,
    output logic done,
    output logic caught,
    output logic overrun,
    output logic timeout_err,
    character_move_scheduler_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, READ, RDWAIT, REQ, WRITE, DONE} state_t;

    state_t             state, state_nx;
    logic [2:0]         idx;
    logic               pending;
    logic [TW-1:0]      tcnt;
    logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y, pac_x, pac_y;
    logic               hit;
    logic               last, to_last, start;

    assign last    = idx == 3'(NUM_CHARS - 1);
    assign to_last = tcnt == TW'(ACK_TIMEOUT - 1);
    assign start   = tick || pending;

    // state register
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next-state: one read, one move request and one write-back per character
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? READ : IDLE;
            READ:    state_nx = RDWAIT;
            RDWAIT:  state_nx = REQ;
            REQ:     state_nx = (bus.mv_ack || to_last) ? WRITE : REQ;
            WRITE:   state_nx = last ? DONE : READ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state and registered data only
    always_comb begin
        bus.reg_en   = (state == READ) || (state == WRITE);
        bus.reg_rw   = state == READ;
        bus.reg_type = ((state == READ) || (state == WRITE)) ? idx : 3'd0;
        bus.reg_x_in = (state == WRITE) ? nxt_x : '0;
        bus.reg_y_in = (state == WRITE) ? nxt_y : '0;
        bus.mv_req   = state == REQ;
        bus.mv_type  = (state == REQ) ? idx : 3'd0;
        bus.mv_x     = (state == REQ) ? cur_x : '0;
        bus.mv_y     = (state == REQ) ? cur_y : '0;
        busy         = state != IDLE;
        done         = state == DONE;
        caught       = (state == DONE) && hit;
    end

    // sweep index, captured coordinates, collision tracking and sticky error flags
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            pending     <= 1'b0;
            tcnt        <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            nxt_x       <= '0;
            nxt_y       <= '0;
            pac_x       <= '0;
            pac_y       <= '0;
            hit         <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == IDLE) && start) idx <= '0;
            else if ((state == WRITE) && !last) idx <= idx + 3'd1;
            pending     <= (state != IDLE) && (pending || tick);
            overrun     <= !clear_err && (overrun || (tick && (state != IDLE)));
            timeout_err <= !clear_err && (timeout_err || ((state == REQ) && !bus.mv_ack && to_last));
            tcnt        <= (state == REQ) ? tcnt + TW'(1) : '0;
            if (state == RDWAIT) begin
                cur_x <= bus.reg_x_out;
                cur_y <= bus.reg_y_out;
            end
            if (state == REQ) begin
                nxt_x <= (bus.mv_ack && bus.mv_ok) ? bus.mv_x_new : cur_x;
                nxt_y <= (bus.mv_ack && bus.mv_ok) ? bus.mv_y_new : cur_y;
            end
            if ((state == READ) && (idx == 3'd0)) hit <= 1'b0;
            else if ((state == WRITE) && (idx != 3'd0) && (nxt_x == pac_x) && (nxt_y == pac_y)) hit <= 1'b1;
            if ((state == WRITE) && (idx == 3'd0)) begin
                pac_x <= nxt_x;
                pac_y <= nxt_y;
            end
        end
    end
endmodule
